timer_core: RTL and testbench

TIMER_CORE -- requirements
Module: timer_core

---
 rtl/timer_core.sv | 95 +++++++++
 tb/tb_timer_core.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_core.sv
// rtl/timer_core.sv - period/PWM timer with one-shot and continuous modes
module timer_core #(
    parameter int CNT_W = 32
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             MODE,
    input  logic             GO_EN,
    input  logic [CNT_W-1:0] TOT_CNT,
    input  logic [CNT_W-1:0] DUTY_CNT,
    output logic             IRQ_TRG,
    output logic             PWM_OUT,
    output logic             BUSY,
    output logic [CNT_W-1:0] CNT_VAL
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO = '0;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] tot_sh_q;
    logic [CNT_W-1:0] duty_sh_q;
    logic             irq_q;

    // tot_sh_q is never zero while in RUN, so the subtraction cannot wrap there
    logic terminal;
    assign terminal = (cnt_q == (tot_sh_q - ONE));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= ZERO;
            tot_sh_q  <= ZERO;
            duty_sh_q <= ZERO;
            irq_q     <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= ZERO;
                    if (GO_EN && (TOT_CNT != ZERO)) begin
                        tot_sh_q  <= TOT_CNT;
                        duty_sh_q <= DUTY_CNT;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!GO_EN) begin
                        // abort wins over a coincident terminal count
                        cnt_q   <= ZERO;
                        state_q <= ST_IDLE;
                    end else if (terminal) begin
                        irq_q <= 1'b1;
                        cnt_q <= ZERO;
                        if (MODE) begin
                            if (TOT_CNT != ZERO) begin
                                tot_sh_q  <= TOT_CNT;
                                duty_sh_q <= DUTY_CNT;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                ST_DONE: begin
                    cnt_q <= ZERO;
                    if (!GO_EN) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    cnt_q   <= ZERO;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign IRQ_TRG = irq_q;
    assign BUSY    = (state_q == ST_RUN);
    assign PWM_OUT = (state_q == ST_RUN) && (cnt_q < duty_sh_q);
    assign CNT_VAL = cnt_q;

endmodule

// File: tb/tb_timer_core.sv
// tb/tb_timer_core.sv - directed self-checking bench for timer_core
module tb_timer_core;

    logic        PCLK;
    logic        PRESETn;
    logic        MODE;
    logic        GO_EN;
    logic [31:0] TOT_CNT;
    logic [31:0] DUTY_CNT;
    logic        IRQ_TRG;
    logic        PWM_OUT;
    logic        BUSY;
    logic [31:0] CNT_VAL;

    int total = 0;
    int bad   = 0;

    timer_core #(.CNT_W(32)) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .MODE     (MODE),
        .GO_EN    (GO_EN),
        .TOT_CNT  (TOT_CNT),
        .DUTY_CNT (DUTY_CNT),
        .IRQ_TRG  (IRQ_TRG),
        .PWM_OUT  (PWM_OUT),
        .BUSY     (BUSY),
        .CNT_VAL  (CNT_VAL)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic busy_e, input logic [31:0] cnt_e,
                           input logic pwm_e, input logic irq_e);
        chk({tag, ".busy"}, {31'd0, BUSY}, {31'd0, busy_e});
        chk({tag, ".cnt"}, CNT_VAL, cnt_e);
        chk({tag, ".pwm"}, {31'd0, PWM_OUT}, {31'd0, pwm_e});
        chk({tag, ".irq"}, {31'd0, IRQ_TRG}, {31'd0, irq_e});
    endtask

    initial begin
        PRESETn  = 1'b0;
        MODE     = 1'b0;
        GO_EN    = 1'b0;
        TOT_CNT  = 32'd0;
        DUTY_CNT = 32'd0;
        #1;
        chk_all("reset", 1'b0, 32'd0, 1'b0, 1'b0);
        step();
        step();
        PRESETn = 1'b1;
        step();
        chk_all("post_reset_idle", 1'b0, 32'd0, 1'b0, 1'b0);

        // one-shot TOT=5 DUTY=2
        TOT_CNT = 32'd5; DUTY_CNT = 32'd2; MODE = 1'b0; GO_EN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all($sformatf("oneshot_c%0d", i), 1'b1, i, (i < 2), 1'b0);
        end
        step();
        chk_all("oneshot_tc", 1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all($sformatf("oneshot_done%0d", i), 1'b0, 32'd0, 1'b0, 1'b0);
        end
        GO_EN = 1'b0;
        step();
        chk_all("oneshot_idle", 1'b0, 32'd0, 1'b0, 1'b0);

        // continuous TOT=4 DUTY=1, duty rewritten mid-period
        TOT_CNT = 32'd4; DUTY_CNT = 32'd1; MODE = 1'b1; GO_EN = 1'b1;
        step();
        chk_all("cont_p0c0", 1'b1, 32'd0, 1'b1, 1'b0);
        step();
        chk_all("cont_p0c1", 1'b1, 32'd1, 1'b0, 1'b0);
        DUTY_CNT = 32'd3;
        step();
        chk_all("cont_p0c2", 1'b1, 32'd2, 1'b0, 1'b0);
        step();
        chk_all("cont_p0c3", 1'b1, 32'd3, 1'b0, 1'b0);
        step();
        chk_all("cont_p1c0", 1'b1, 32'd0, 1'b1, 1'b1);
        step();
        chk_all("cont_p1c1", 1'b1, 32'd1, 1'b1, 1'b0);
        step();
        chk_all("cont_p1c2", 1'b1, 32'd2, 1'b1, 1'b0);
        step();
        chk_all("cont_p1c3", 1'b1, 32'd3, 1'b0, 1'b0);
        step();
        chk_all("cont_p2c0", 1'b1, 32'd0, 1'b1, 1'b1);
        GO_EN = 1'b0;
        step();
        chk_all("cont_stop", 1'b0, 32'd0, 1'b0, 1'b0);

        // saturation high
        TOT_CNT = 32'd3; DUTY_CNT = 32'd7; MODE = 1'b0; GO_EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("sat1_c%0d", i), 1'b1, i, 1'b1, 1'b0);
        end
        step();
        chk_all("sat1_tc", 1'b0, 32'd0, 1'b0, 1'b1);
        GO_EN = 1'b0;
        step();

        // saturation low
        DUTY_CNT = 32'd0; GO_EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("sat0_c%0d", i), 1'b1, i, 1'b0, 1'b0);
        end
        step();
        chk_all("sat0_tc", 1'b0, 32'd0, 1'b0, 1'b1);
        GO_EN = 1'b0;
        step();

        // invalid period
        TOT_CNT = 32'd0;
        GO_EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("tot0_%0d", i), 1'b0, 32'd0, 1'b0, 1'b0);
        end
        GO_EN = 1'b0;
        step();

        // abort at cnt=3
        TOT_CNT = 32'd10; DUTY_CNT = 32'd5; MODE = 1'b0; GO_EN = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk_all("abort3_pre", 1'b1, 32'd3, 1'b1, 1'b0);
        GO_EN = 1'b0;
        step();
        chk_all("abort3", 1'b0, 32'd0, 1'b0, 1'b0);
        step();
        chk_all("abort3_after", 1'b0, 32'd0, 1'b0, 1'b0);

        // abort coincident with terminal count
        GO_EN = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk_all("abort9_pre", 1'b1, 32'd9, 1'b0, 1'b0);
        GO_EN = 1'b0;
        step();
        chk_all("abort9", 1'b0, 32'd0, 1'b0, 1'b0);
        step();
        chk_all("abort9_after", 1'b0, 32'd0, 1'b0, 1'b0);

        // continuous reload to zero
        TOT_CNT = 32'd4; DUTY_CNT = 32'd2; MODE = 1'b1; GO_EN = 1'b1;
        step();
        chk_all("rz_c0", 1'b1, 32'd0, 1'b1, 1'b0);
        TOT_CNT = 32'd0;
        for (int i = 1; i < 4; i++) begin
            step();
            chk_all($sformatf("rz_c%0d", i), 1'b1, i, (i < 2), 1'b0);
        end
        step();
        chk_all("rz_tc", 1'b0, 32'd0, 1'b0, 1'b1);
        step();
        chk_all("rz_idle", 1'b0, 32'd0, 1'b0, 1'b0);
        GO_EN = 1'b0;
        step();

        // asynchronous reset mid-run
        TOT_CNT = 32'd10; DUTY_CNT = 32'd8; MODE = 1'b0; GO_EN = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk_all("ar_pre", 1'b1, 32'd6, 1'b1, 1'b0);
        #2;
        PRESETn = 1'b0;
        #1;
        chk_all("ar_async", 1'b0, 32'd0, 1'b0, 1'b0);
        step();
        chk_all("ar_held", 1'b0, 32'd0, 1'b0, 1'b0);
        TOT_CNT = 32'd2;
        PRESETn = 1'b1;
        step();
        chk_all("ar_restart_c0", 1'b1, 32'd0, 1'b1, 1'b0);
        step();
        chk_all("ar_restart_c1", 1'b1, 32'd1, 1'b1, 1'b0);
        step();
        chk_all("ar_restart_tc", 1'b0, 32'd0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
